// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch defaults, fetch FSM encoding and
// the fetch-queue entry layout.
package cpu_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEFAULT = 4096;
    localparam int unsigned DEPTH_DEFAULT    = 2;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Word aligned and inside [base, base + 4*words); 34-bit math keeps the bound from wrapping.
    function automatic logic fetch_addr_ok(input logic [31:0] pc,
                                           input logic [31:0] base,
                                           input logic [31:0] words);
        logic [33:0] limit;
        limit = {2'b00, base} + {words, 2'b00};
        return (pc[1:0] == 2'b00) && (pc >= base) && ({2'b00, pc} < limit);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction-memory port, decode redirect and the
// valid/ready instruction stream towards decode.
interface fetch_ctrl_if;

    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        addr_error;

    modport master (
        output im_addr,
        input  im_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output addr_error
    );

    modport slave (
        input  im_addr,
        output im_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  addr_error
    );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue: power-of-two circular buffer with flush and same-cycle
// push+pop while full.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          pop_s;
    logic          push_s;

    // Qualify requests: pop needs data, push needs room unless the head leaves this cycle.
    always_comb begin
        pop_s  = pop && (count_r != {CW{1'b0}});
        push_s = push && ((count_r != CW'(DEPTH)) || pop_s);
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; when full, push lands in the slot the popped head is vacating.
    always_ff @(posedge clk) begin
        if (push_s && !reset && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks fetch_pc through instruction memory,
// queues {pc, instr} for decode, honours redirects and parks on bad addresses.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int unsigned IM_WORDS = IM_WORDS_DEFAULT,
    parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_e  state_r;
    fetch_state_e  state_next_s;
    logic [31:0]   fetch_pc_r;
    logic          addr_error_r;
    logic          addr_ok_s;
    logic          pop_s;
    logic          push_s;
    logic          fault_set_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    fetch_entry_t  tail_s;
    fetch_entry_t  head_s;

    assign addr_ok_s = fetch_addr_ok(fetch_pc_r, PC_RESET, 32'(IM_WORDS));
    assign pop_s     = !fifo_empty_s && bus.out_ready;
    assign tail_s    = '{pc: fetch_pc_r, instr: bus.im_instr};

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: a redirect always restarts fetch, a bad address parks in FAULT.
    always_comb begin
        state_next_s = state_r;
        if (bus.redirect_valid) begin
            state_next_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (!addr_ok_s) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_FAULT: state_next_s = ST_FAULT;
                default:  state_next_s = ST_RUN;
            endcase
        end
    end

    // FSM outputs: queue push and fault-flag set
    always_comb begin
        push_s      = 1'b0;
        fault_set_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    push_s      = 1'b0;
                    fault_set_s = 1'b0;
                end else if (addr_ok_s) begin
                    push_s      = !fifo_full_s || pop_s;
                    fault_set_s = 1'b0;
                end else begin
                    push_s      = 1'b0;
                    fault_set_s = 1'b1;
                end
            end
            default: begin
                push_s      = 1'b0;
                fault_set_s = 1'b0;
            end
        endcase
    end

    // Fetch PC and sticky address-fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r   <= PC_RESET;
            addr_error_r <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc_r   <= bus.redirect_pc;
            addr_error_r <= 1'b0;
        end else begin
            if (push_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (fault_set_s) begin
                addr_error_r <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (bus.redirect_valid),
        .wdata (tail_s),
        .rdata (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign bus.im_addr    = fetch_pc_r;
    assign bus.out_valid  = (fifo_count_s != {CW{1'b0}});
    assign bus.out_instr  = head_s.instr;
    assign bus.out_pc     = head_s.pc;
    assign bus.addr_error = addr_error_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle vector table plus hand sequences,
// with a scoreboard of the pc stream decode is expected to accept.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    localparam logic [31:0] KEY = 32'hC0DE_5A5A;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eim;
        logic        eerr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb [$];
    vec_t        tbl [9];

    fetch_ctrl_if bus ();

    // Instruction memory model: word content derived from its address.
    assign bus.im_instr = bus.im_addr ^ KEY;

    fetch_ctrl #(
        .PC_RESET (32'h0000_3000),
        .IM_WORDS (4096),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; score any handshake that will complete at the coming edge.
    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] exp_pc;
        reset              = rst;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        #1;
        if (bus.out_valid && rdy && !rv && !rst) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_delivery: got pc %h expected no delivery", bus.out_pc);
            end else begin
                exp_pc = sb.pop_front();
                check32("delivered_pc", bus.out_pc, exp_pc);
                check32("delivered_instr", bus.out_instr, exp_pc ^ KEY);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic ev, input logic [31:0] epc,
                       input logic [31:0] eim, input logic eerr);
        check32({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ev});
        if (ev) begin
            check32({tag, ".out_pc"}, bus.out_pc, epc);
            check32({tag, ".out_instr"}, bus.out_instr, epc ^ KEY);
        end
        check32({tag, ".im_addr"}, bus.im_addr, eim);
        check32({tag, ".addr_error"}, {31'd0, bus.addr_error}, {31'd0, eerr});
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("reset", 1'b0, 32'h0, 32'h0000_3000, 1'b0);

        // Streaming with out_ready=1, mid-run reset, then out_ready=0 for five cycles
        tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'h3004, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3004, 32'h3008, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3008, 32'h300C, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,    32'h3000, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 32'h3004, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 32'h3008, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 32'h3008, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 32'h3008, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000, 32'h3008, 1'b0};
        sb.push_back(32'h3000);
        sb.push_back(32'h3004);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eim, tbl[i].eerr);
        end

        // Push and pop together while full, then redirect flushes the queue
        sb.push_back(32'h3000);
        sb.push_back(32'h3100);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("full_push_pop", 1'b1, 32'h3004, 32'h300C, 1'b0);
        step(1'b0, 1'b1, 32'h3100, 1'b1);
        chk("redir_flush", 1'b0, 32'h0, 32'h3100, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_first", 1'b1, 32'h3100, 32'h3104, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_second", 1'b1, 32'h3104, 32'h3108, 1'b0);

        // Last legal word, then fault on the word past the end
        sb.push_back(32'h6FFC);
        step(1'b0, 1'b1, 32'h6FFC, 1'b1);
        chk("top_redir", 1'b0, 32'h0, 32'h6FFC, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("top_push", 1'b1, 32'h6FFC, 32'h7000, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("top_fault", 1'b0, 32'h0, 32'h7000, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("top_fault_hold", 1'b0, 32'h0, 32'h7000, 1'b1);

        // Entries queued before a fault still drain while in FAULT
        sb.push_back(32'h6FF8);
        sb.push_back(32'h6FFC);
        step(1'b0, 1'b1, 32'h6FF8, 1'b0);
        chk("drain_redir", 1'b0, 32'h0, 32'h6FF8, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain_push1", 1'b1, 32'h6FF8, 32'h6FFC, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain_push2", 1'b1, 32'h6FF8, 32'h7000, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain_fault", 1'b1, 32'h6FF8, 32'h7000, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_pop1", 1'b1, 32'h6FFC, 32'h7000, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_pop2", 1'b0, 32'h0, 32'h7000, 1'b1);

        // Misaligned target faults; a good redirect clears the flag and resumes
        step(1'b0, 1'b1, 32'h3002, 1'b1);
        chk("misal_redir", 1'b0, 32'h0, 32'h3002, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("misal_fault", 1'b0, 32'h0, 32'h3002, 1'b1);
        step(1'b0, 1'b1, 32'h3000, 1'b1);
        chk("misal_recover", 1'b0, 32'h0, 32'h3000, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("misal_resume", 1'b1, 32'h3000, 32'h3004, 1'b0);

        // Reset wins over a simultaneous redirect while full
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_fill", 1'b1, 32'h3000, 32'h3008, 1'b0);
        step(1'b1, 1'b1, 32'h3100, 1'b1);
        chk("rst_over_redir", 1'b0, 32'h0, 32'h3000, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_release", 1'b1, 32'h3000, 32'h3004, 1'b0);

        check32("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, first fetch address after reset.
REQ-002 SHALL have parameter IM_WORDS, default 4096, number of instruction-memory words.
REQ-003 SHALL have parameter DEPTH, default 2, fetch-queue entries (power of two, >=2).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port im_addr  out  32  byte address driven to instruction memory (combinational read).
REQ-007 SHALL have port im_instr  in  32  instruction word returned for im_addr in the same cycle.
REQ-008 SHALL have port redirect_valid  in  1  branch/jump target request from decode.
REQ-009 SHALL have port redirect_pc  in  32  target byte address.
REQ-010 SHALL have port out_valid  out  1  queue head holds an instruction.
REQ-011 SHALL have port out_ready  in  1  decode accepts head.
REQ-012 SHALL have port out_instr  out  32  head instruction.
REQ-013 SHALL have port out_pc  out  32  head byte address.
REQ-014 SHALL have port addr_error  out  1  sticky fetch-address fault flag.

Function
REQ-015 SHALL hold fetch_pc register; im_addr = fetch_pc at all times.
REQ-016 SHALL be in state RUN or FAULT; FSM state and queue count are the only control state.
REQ-017 SHALL define addr_ok = fetch_pc[1:0]==0 and PC_RESET <= fetch_pc < PC_RESET + 4*IM_WORDS (0x3000..0x6FFC by default).
REQ-018 SHALL define pop = out_valid && out_ready; a pop removes the head at the clock edge.
REQ-019 SHALL define push = RUN && !redirect_valid && addr_ok && (count<DEPTH || pop); push writes {fetch_pc, im_instr} at tail and sets fetch_pc += 4.
REQ-020 SHALL allow push and pop in the same cycle when full; count unchanged, ordering preserved.
REQ-021 SHALL, in RUN with !redirect_valid and !addr_ok, enter FAULT next cycle, push nothing, leave fetch_pc unchanged, set addr_error.
REQ-022 SHALL, in FAULT, perform no push; queued entries still drain via pop; addr_error stays 1.
REQ-023 SHALL, on redirect_valid (any state), at the edge: clear queue (count=0), load fetch_pc=redirect_pc, enter RUN, clear addr_error; redirect overrides push and pop that cycle.
REQ-024 SHALL drive out_valid = (count!=0); out_instr/out_pc = head entry; values when out_valid=0 are don't-care but stable.
REQ-025 SHALL hold head contents stable while out_valid && !out_ready.
REQ-026 SHALL give one-cycle latency: word fetched at edge N is visible on out_* after edge N.
REQ-027 SHALL wrap queue read/write pointers modulo DEPTH without affecting count.
REQ-028 SHALL not check redirect_pc at load; it is checked by REQ-021 on the next fetch attempt.

Reset
REQ-029 SHALL, when reset=1 at an edge, set fetch_pc=PC_RESET, count=0, pointers=0, state=RUN, addr_error=0, overriding redirect and handshakes.
REQ-030 SHALL produce out_valid=0, addr_error=0, im_addr=PC_RESET in the cycle after reset, including reset asserted mid-operation.

Structure
REQ-031 SHALL place PC_RESET, IM_WORDS, DEPTH defaults and state encodings (RUN=0, FAULT=1) in shared package cpu_pkg.
REQ-032 SHALL implement the queue as sub-module fetch_fifo (push/pop/flush, count, full/empty, same-cycle push+pop when full).
REQ-033 SHALL contain no combinational path from out_ready to im_addr.

Verification
REQ-034 SHALL test reset release, out_ready=1 constant -> out_pc 0x3000,0x3004,0x3008 on consecutive cycles, out_valid high from cycle 2.
REQ-035 SHALL test out_ready=0 for 5 cycles after reset -> count saturates at 2, im_addr holds 0x3008, head stays pc 0x3000.
REQ-036 SHALL test redirect_valid with redirect_pc=0x3100 while full and out_ready=1 -> queue flushed, next out_pc=0x3100, no 0x3008 delivered.
REQ-037 SHALL test redirect to 0x6FFC, out_ready=1 -> 0x6FFC delivered, then FAULT, addr_error=1, out_valid=0 after drain.
REQ-038 SHALL test redirect to 0x3002 -> no push, addr_error=1 next cycle; then redirect to 0x3000 -> addr_error=0, fetch resumes.
REQ-039 SHALL test reset asserted while full and redirect_valid=1 -> out_valid=0, im_addr=0x3000 next cycle.
